// File: rtl/alu_status_if.sv
// Operand, control and status bundle between the operand-select stage,
// the controller and the ALU/status unit.
interface alu_status_if;
  logic       stall;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [3:0] alu_op;
  logic [1:0] cin_sel;
  logic [7:0] flag_we;
  logic [7:0] flag_set;
  logic [7:0] flag_clr;
  logic       irq_set_i;
  logic       p_load;
  logic [7:0] p_load_data;
  logic       push_brk;
  logic [7:0] result;
  logic       cout;
  logic [7:0] temp_status;
  logic [7:0] status;
  logic [7:0] p_push;

  modport master (
    output stall, in1, in2, alu_op, cin_sel, flag_we, flag_set, flag_clr,
           irq_set_i, p_load, p_load_data, push_brk,
    input  result, cout, temp_status, status, p_push
  );

  modport slave (
    input  stall, in1, in2, alu_op, cin_sel, flag_we, flag_set, flag_clr,
           irq_set_i, p_load, p_load_data, push_brk,
    output result, cout, temp_status, status, p_push
  );
endinterface

// File: rtl/alu_status_unit.sv
// 6502-compatible ALU with registered result/carry and the P status register.
// D is storage only: the 2A03 has no decimal mode.
module alu_status_unit (
  input  logic         clk,
  input  logic         rst,
  alu_status_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_EOR   = 4'd4,
    OP_ASL   = 4'd5,
    OP_LSR   = 4'd6,
    OP_ROL   = 4'd7,
    OP_ROR   = 4'd8,
    OP_PASS1 = 4'd9,
    OP_PASS2 = 4'd10,
    OP_BIT   = 4'd11,
    OP_CMP   = 4'd12,
    OP_INC   = 4'd13,
    OP_DEC   = 4'd14,
    OP_ADDR  = 4'd15
  } alu_op_e;

  alu_op_e    op;
  logic [7:0] p;
  logic [7:0] p_next;
  logic [7:0] p_loaded;
  logic [7:0] p_masked;
  logic [7:0] result_q;
  logic       cout_q;

  logic       cin;
  logic       carry_eff;
  logic [7:0] operand_b;
  logic [8:0] sum;
  logic       overflow;
  logic [7:0] r;
  logic [7:0] temp;
  logic       n_new;
  logic       v_new;
  logic       z_new;
  logic       c_new;
  logic       nz_from_r;

  assign op = alu_op_e'(bus.alu_op);

  // One shared adder serves ADD, SUB, CMP and ADDR; SUB/CMP invert in2.
  always_comb begin
    cin = 1'b0;
    case (bus.cin_sel)
      2'd1:    cin = 1'b1;
      2'd2:    cin = p[0];
      default: cin = 1'b0;
    endcase
    operand_b = ((op == OP_SUB) || (op == OP_CMP)) ? ~bus.in2 : bus.in2;
    carry_eff = (op == OP_CMP) ? 1'b1 : cin;
    sum       = {1'b0, bus.in1} + {1'b0, operand_b} + {8'd0, carry_eff};
    overflow  = ~(bus.in1[7] ^ operand_b[7]) & (bus.in1[7] ^ sum[7]);
  end

  always_comb begin
    r         = sum[7:0];
    n_new     = p[7];
    v_new     = p[6];
    z_new     = p[1];
    c_new     = p[0];
    nz_from_r = 1'b1;
    case (op)
      OP_ADD, OP_SUB: begin
        c_new = sum[8];
        v_new = overflow;
      end
      OP_AND:   r = bus.in1 & bus.in2;
      OP_OR:    r = bus.in1 | bus.in2;
      OP_EOR:   r = bus.in1 ^ bus.in2;
      OP_ASL: begin
        r     = {bus.in1[6:0], 1'b0};
        c_new = bus.in1[7];
      end
      OP_LSR: begin
        r     = {1'b0, bus.in1[7:1]};
        c_new = bus.in1[0];
      end
      OP_ROL: begin
        r     = {bus.in1[6:0], cin};
        c_new = bus.in1[7];
      end
      OP_ROR: begin
        r     = {cin, bus.in1[7:1]};
        c_new = bus.in1[0];
      end
      OP_PASS1: r = bus.in1;
      OP_PASS2: r = bus.in2;
      OP_BIT: begin
        r         = bus.in1 & bus.in2;
        nz_from_r = 1'b0;
        z_new     = (r == 8'h00);
        n_new     = bus.in2[7];
        v_new     = bus.in2[6];
      end
      OP_CMP:   c_new = sum[8];
      OP_INC:   r = bus.in1 + 8'd1;
      OP_DEC:   r = bus.in1 - 8'd1;
      OP_ADDR: begin
        // Address add: only C and N are meaningful for page-cross fixup.
        nz_from_r = 1'b0;
        c_new     = sum[8];
        n_new     = bus.in2[7];
      end
      default: r = sum[7:0];
    endcase
    if (nz_from_r) begin
      n_new = r[7];
      z_new = (r == 8'h00);
    end
    temp = {n_new, v_new, 1'b1, 1'b0, p[3], p[2], z_new, c_new};
  end

  // Write mask first, then clear, then set, so set wins; IRQ entry forces I last.
  always_comb begin
    p_loaded = (bus.p_load_data | 8'h20) & 8'hEF;
    p_masked = (((p & ~bus.flag_we) | (temp & bus.flag_we)) & ~bus.flag_clr) | bus.flag_set;
    p_next   = bus.p_load ? p_loaded : p_masked;
    if (!bus.p_load && bus.irq_set_i) begin
      p_next[2] = 1'b1;
    end
    p_next[5] = 1'b1;
    p_next[4] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 8'h00;
      cout_q   <= 1'b0;
      p        <= 8'h24;
    end else if (!bus.stall) begin
      result_q <= r;
      cout_q   <= temp[0];
      p        <= p_next;
    end
  end

  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
  assign bus.temp_status = temp;
  assign bus.status      = p;
  assign bus.p_push      = {p[7:6], 1'b1, bus.push_brk, p[3:0]};

endmodule

// File: tb/tb_alu_status_unit.sv
// Randomized and directed checks of alu_status_unit against an arithmetic
// reference model of the 6502 ALU and P register.
module tb_alu_status_unit;

  logic clk;
  logic rst;
  logic check_en;
  int   vectors;
  int   miscompares;

  logic [7:0] m_p;
  logic [7:0] m_result;
  logic       m_cout;
  logic [7:0] m_t;
  logic [7:0] m_r;
  logic [7:0] c_t;
  logic [7:0] c_r;

  alu_status_if bus ();

  alu_status_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit out_of_range(input int v);
    return (v > 127) || (v < -128);
  endfunction

  // Reference ALU: plain integer arithmetic on unsigned/signed views of operands.
  function automatic logic [7:0] model_temp(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [1:0] cs,
                                            input logic [7:0] p, output logic [7:0] r);
    int ua, ub, sa, sb, s, ss, cin, rv;
    bit n, v, z, c, nz;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    cin = (cs == 2'd1) ? 1 : ((cs == 2'd2) ? int'(p[0]) : 0);
    n = p[7]; v = p[6]; z = p[1]; c = p[0]; nz = 1'b1;
    s = 0; ss = 0;
    case (op)
      4'd0: begin s = ua + ub + cin; ss = sa + sb + cin; c = (s > 255); v = out_of_range(ss); end
      4'd1: begin s = ua - ub - (1 - cin); ss = sa - sb - (1 - cin); c = (s >= 0); v = out_of_range(ss); end
      4'd2: s = ua & ub;
      4'd3: s = ua | ub;
      4'd4: s = ua ^ ub;
      4'd5: begin s = ua * 2; c = (ua >= 128); end
      4'd6: begin s = ua / 2; c = (ua % 2 == 1); end
      4'd7: begin s = (ua * 2) % 256 + cin; c = (ua >= 128); end
      4'd8: begin s = ua / 2 + cin * 128; c = (ua % 2 == 1); end
      4'd9: s = ua;
      4'd10: s = ub;
      4'd11: begin s = ua & ub; z = (s == 0); n = b[7]; v = b[6]; nz = 1'b0; end
      4'd12: begin s = ua - ub; c = (ua >= ub); end
      4'd13: s = ua + 1;
      4'd14: s = ua - 1;
      default: begin s = ua + ub + cin; c = (s > 255); n = b[7]; nz = 1'b0; end
    endcase
    rv = (s + 512) % 256;
    r = 8'(rv);
    if (nz) begin
      z = (rv == 0);
      n = (rv >= 128);
    end
    return {n, v, 1'b1, 1'b0, p[3], p[2], z, c};
  endfunction

  function automatic logic [7:0] model_next_p(input logic [7:0] p, input logic [7:0] t,
                                              input logic [7:0] we, input logic [7:0] set,
                                              input logic [7:0] clr, input logic irq,
                                              input logic pl, input logic [7:0] d);
    logic [7:0] nxt;
    if (pl) return (d | 8'h20) & 8'hEF;
    for (int i = 0; i < 8; i++) begin
      if (set[i])      nxt[i] = 1'b1;
      else if (clr[i]) nxt[i] = 1'b0;
      else if (we[i])  nxt[i] = t[i];
      else             nxt[i] = p[i];
    end
    if (irq) nxt[2] = 1'b1;
    nxt[5] = 1'b1;
    nxt[4] = 1'b0;
    return nxt;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p      = 8'h24;
      m_result = 8'h00;
      m_cout   = 1'b0;
    end else if (!bus.stall) begin
      m_t      = model_temp(bus.alu_op, bus.in1, bus.in2, bus.cin_sel, m_p, m_r);
      m_result = m_r;
      m_cout   = m_t[0];
      m_p      = model_next_p(m_p, m_t, bus.flag_we, bus.flag_set, bus.flag_clr,
                              bus.irq_set_i, bus.p_load, bus.p_load_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      c_t = model_temp(bus.alu_op, bus.in1, bus.in2, bus.cin_sel, m_p, c_r);
      check_output("temp_status", bus.temp_status, c_t);
      check_output("result", bus.result, m_result);
      check_output("cout", {7'd0, bus.cout}, {7'd0, m_cout});
      check_output("status", bus.status, m_p);
      check_output("p_push", bus.p_push, (m_p & 8'hEF) | 8'h20 | {3'd0, bus.push_brk, 4'd0});
    end
  end

  task automatic set_idle();
    bus.stall       = 1'b0;
    bus.in1         = 8'h00;
    bus.in2         = 8'h00;
    bus.alu_op      = 4'd0;
    bus.cin_sel     = 2'd0;
    bus.flag_we     = 8'h00;
    bus.flag_set    = 8'h00;
    bus.flag_clr    = 8'h00;
    bus.irq_set_i   = 1'b0;
    bus.p_load      = 1'b0;
    bus.p_load_data = 8'h00;
    bus.push_brk    = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] cs, input logic [7:0] we);
    set_idle();
    bus.alu_op  = op;
    bus.in1     = a;
    bus.in2     = b;
    bus.cin_sel = cs;
    bus.flag_we = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    rst         = 1'b0;
    set_idle();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset status", bus.status, 8'h24);
    check_output("reset result", bus.result, 8'h00);
    check_output("reset cout", {7'd0, bus.cout}, 8'h00);
    check_output("reset p_push", bus.p_push, 8'h24);
    check_en = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      bus.alu_op      = 4'($urandom_range(0, 15));
      bus.in1         = 8'($urandom);
      bus.in2         = 8'($urandom);
      bus.cin_sel     = 2'($urandom);
      bus.flag_we     = 8'($urandom);
      bus.flag_set    = 8'($urandom & $urandom & $urandom);
      bus.flag_clr    = 8'($urandom & $urandom & $urandom);
      bus.irq_set_i   = ($urandom_range(0, 19) == 0);
      bus.p_load      = ($urandom_range(0, 15) == 0);
      bus.p_load_data = 8'($urandom);
      bus.stall       = ($urandom_range(0, 7) == 0);
      bus.push_brk    = 1'($urandom);
      step();
    end

    // Asynchronous reset in the middle of traffic.
    #2 rst = 1'b1;
    #1;
    check_output("midreset status", bus.status, 8'h24);
    check_output("midreset result", bus.result, 8'h00);
    check_output("midreset cout", {7'd0, bus.cout}, 8'h00);
    set_idle();
    @(negedge clk);
    #2 rst = 1'b0;
    step();

    apply_stimulus(4'd0, 8'h50, 8'h50, 2'd0, 8'hC3);
    step();
    check_output("add result", bus.result, 8'hA0);
    check_output("add status", bus.status, 8'hE4);

    apply_stimulus(4'd1, 8'h00, 8'h01, 2'd1, 8'hC3);
    step();
    check_output("sub result", bus.result, 8'hFF);
    check_output("sub status", bus.status, 8'hA4);

    apply_stimulus(4'd12, 8'h42, 8'h42, 2'd0, 8'h83);
    step();
    check_output("cmp result", bus.result, 8'h00);
    check_output("cmp status", bus.status, 8'h27);

    apply_stimulus(4'd15, 8'hF0, 8'h20, 2'd0, 8'h00);
    #1;
    check_output("addr1 temp", bus.temp_status, 8'h27);
    step();
    check_output("addr1 result", bus.result, 8'h10);
    check_output("addr1 cout", {7'd0, bus.cout}, 8'h01);
    check_output("addr1 status", bus.status, 8'h27);

    apply_stimulus(4'd15, 8'h10, 8'hF0, 2'd0, 8'h00);
    #1;
    check_output("addr2 temp", bus.temp_status, 8'hA7);
    step();
    check_output("addr2 result", bus.result, 8'h00);
    check_output("addr2 cout", {7'd0, bus.cout}, 8'h01);

    apply_stimulus(4'd8, 8'h01, 8'h00, 2'd2, 8'h83);
    step();
    check_output("ror result", bus.result, 8'h80);
    check_output("ror status", bus.status, 8'hA5);

    apply_stimulus(4'd11, 8'h00, 8'hC0, 2'd0, 8'hC2);
    step();
    check_output("bit result", bus.result, 8'h00);
    check_output("bit status", bus.status, 8'hE7);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(4'(i + 1), 8'h3C + 8'(i), 8'h81, 2'd1, 8'hFF);
      bus.stall       = 1'b1;
      bus.p_load      = 1'b1;
      bus.p_load_data = 8'h00;
      bus.flag_set    = 8'hFF;
      step();
      check_output("stall result", bus.result, 8'h00);
      check_output("stall cout", {7'd0, bus.cout}, 8'h01);
      check_output("stall status", bus.status, 8'hE7);
    end

    apply_stimulus(4'd13, 8'h7F, 8'h00, 2'd0, 8'h82);
    step();
    check_output("inc result", bus.result, 8'h80);
    check_output("inc status", bus.status, 8'hE5);

    set_idle();
    bus.p_load      = 1'b1;
    bus.p_load_data = 8'hFF;
    step();
    check_output("pload ff", bus.status, 8'hEF);

    set_idle();
    bus.flag_clr = 8'h01;
    step();
    check_output("clc", bus.status, 8'hEE);

    set_idle();
    bus.flag_set = 8'h01;
    bus.flag_clr = 8'h01;
    step();
    check_output("set wins", bus.status, 8'hEF);

    set_idle();
    bus.p_load      = 1'b1;
    bus.p_load_data = 8'h00;
    step();
    check_output("pload 00", bus.status, 8'h20);

    set_idle();
    bus.irq_set_i = 1'b1;
    bus.flag_clr  = 8'h04;
    step();
    check_output("irq wins", bus.status, 8'h24);

    set_idle();
    bus.push_brk = 1'b1;
    #1;
    check_output("p_push brk", bus.p_push, 8'h34);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
